// File: rtl/sdram_arbiter.sv
// Three-client arbiter in front of the SDRAM controller command port.
// Client 0 has priority bounded by a starvation limit; clients 1/2 share round-robin.
module sdram_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [15:0]       c0_wdata,
  input  logic [1:0]        c0_be,
  output logic              c0_ack,
  output logic [15:0]       c0_rdata,
  output logic              c0_rvalid,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [15:0]       c1_wdata,
  input  logic [1:0]        c1_be,
  output logic              c1_ack,
  output logic [15:0]       c1_rdata,
  output logic              c1_rvalid,
  input  logic              c2_req,
  input  logic              c2_we,
  input  logic [ADDR_W-1:0] c2_addr,
  input  logic [15:0]       c2_wdata,
  input  logic [1:0]        c2_be,
  output logic              c2_ack,
  output logic [15:0]       c2_rdata,
  output logic              c2_rvalid,
  output logic              ctrl_req,
  output logic              ctrl_we,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [15:0]       ctrl_wdata,
  output logic [1:0]        ctrl_be,
  input  logic              ctrl_ack,
  input  logic [15:0]       ctrl_rdata,
  input  logic              ctrl_rvalid,
  output logic              rd_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t            state, state_nx;
  logic [1:0]        grant;
  logic [1:0]        sel;
  logic              sel_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic [1:0]        sel_be;
  logic              rr_two;
  logic [3:0]        starve;
  logic [7:0]        wd;
  logic              others;
  logic              take;
  logic              rd_done;
  logic              rd_to;
  logic [15:0]       rd_val;

  assign others   = c1_req | c2_req;
  assign ctrl_req = (state == ISSUE);
  assign rd_val   = rd_done ? ctrl_rdata : 16'hFFFF;

  // Client 0 yields only once it has starved a waiting peer STARVE_MAX times.
  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b0;
    if (c0_req && !(others && starve == 4'(STARVE_MAX))) begin
      sel_valid = 1'b1;
    end else if (c1_req && c2_req) begin
      sel       = rr_two ? 2'd2 : 2'd1;
      sel_valid = 1'b1;
    end else if (c1_req) begin
      sel       = 2'd1;
      sel_valid = 1'b1;
    end else if (c2_req) begin
      sel       = 2'd2;
      sel_valid = 1'b1;
    end
  end

  always_comb begin
    sel_we    = c0_we;
    sel_addr  = c0_addr;
    sel_wdata = c0_wdata;
    sel_be    = c0_be;
    case (sel)
      2'd1: begin
        sel_we    = c1_we;
        sel_addr  = c1_addr;
        sel_wdata = c1_wdata;
        sel_be    = c1_be;
      end
      2'd2: begin
        sel_we    = c2_we;
        sel_addr  = c2_addr;
        sel_wdata = c2_wdata;
        sel_be    = c2_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    rd_done  = 1'b0;
    rd_to    = 1'b0;
    c0_ack   = 1'b0;
    c1_ack   = 1'b0;
    c2_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (init_done && sel_valid) begin
          take     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (ctrl_ack) begin
          c0_ack   = (grant == 2'd0);
          c1_ack   = (grant == 2'd1);
          c2_ack   = (grant == 2'd2);
          state_nx = ctrl_we ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (ctrl_rvalid) begin
          rd_done  = 1'b1;
          state_nx = IDLE;
        end else if (wd == 8'(RD_TIMEOUT - 1)) begin
          rd_to    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 2'd0;
      ctrl_we    <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      ctrl_be    <= '0;
      rr_two     <= 1'b0;
      starve     <= '0;
      wd         <= '0;
      c0_rdata   <= '0;
      c1_rdata   <= '0;
      c2_rdata   <= '0;
      c0_rvalid  <= 1'b0;
      c1_rvalid  <= 1'b0;
      c2_rvalid  <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c2_rvalid <= 1'b0;
      if (take) begin
        grant      <= sel;
        ctrl_we    <= sel_we;
        ctrl_addr  <= sel_addr;
        ctrl_wdata <= sel_wdata;
        ctrl_be    <= sel_be;
        if (sel == 2'd0) begin
          if (!others)                          starve <= '0;
          else if (starve != 4'(STARVE_MAX))    starve <= starve + 4'd1;
        end else begin
          starve <= '0;
          rr_two <= (sel == 2'd1);
        end
      end
      if (state == ISSUE)        wd <= '0;
      else if (state == WAIT_RD) wd <= wd + 8'd1;
      if (rd_done || rd_to) begin
        case (grant)
          2'd0: begin c0_rdata <= rd_val; c0_rvalid <= 1'b1; end
          2'd1: begin c1_rdata <= rd_val; c1_rvalid <= 1'b1; end
          2'd2: begin c2_rdata <= rd_val; c2_rvalid <= 1'b1; end
          default: ;
        endcase
      end
      if (rd_to) rd_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised and directed bench for sdram_arbiter against a transaction-level model.
module tb_sdram_arbiter;
  localparam int AW   = 22;
  localparam int SMAX = 4;
  localparam int RTO  = 64;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          c_req[3];
  logic          c_we[3];
  logic [AW-1:0] c_addr[3];
  logic [15:0]   c_wdata[3];
  logic [1:0]    c_be[3];
  logic          c0_ack, c1_ack, c2_ack, c0_rvalid, c1_rvalid, c2_rvalid;
  logic [15:0]   c0_rdata, c1_rdata, c2_rdata;
  logic          ctrl_req, ctrl_we;
  logic [AW-1:0] ctrl_addr;
  logic [15:0]   ctrl_wdata;
  logic [1:0]    ctrl_be;
  logic          ctrl_ack = 1'b0;
  logic          ctrl_rvalid = 1'b0;
  logic [15:0]   ctrl_rdata = '0;
  logic          rd_timeout;

  sdram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .RD_TIMEOUT(RTO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .init_done(init_done),
    .c0_req(c_req[0]), .c0_we(c_we[0]), .c0_addr(c_addr[0]), .c0_wdata(c_wdata[0]), .c0_be(c_be[0]),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c1_req(c_req[1]), .c1_we(c_we[1]), .c1_addr(c_addr[1]), .c1_wdata(c_wdata[1]), .c1_be(c_be[1]),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .c2_req(c_req[2]), .c2_we(c_we[2]), .c2_addr(c_addr[2]), .c2_wdata(c_wdata[2]), .c2_be(c_be[2]),
    .c2_ack(c2_ack), .c2_rdata(c2_rdata), .c2_rvalid(c2_rvalid),
    .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_be(ctrl_be), .ctrl_ack(ctrl_ack), .ctrl_rdata(ctrl_rdata), .ctrl_rvalid(ctrl_rvalid),
    .rd_timeout(rd_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;

  // transaction-level model
  bit            m_busy, m_acked, m_to;
  int            m_cli, m_wait, m_starve, m_pref, m_rv, iss_cnt;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata;
  logic [1:0]    m_be;
  logic [15:0]   m_rdata[3];
  bit            got_ack[3];
  int            gq[$];

  // stimulus policy
  int want[3], keep[3], wmode[3];
  int ack_delay, ack_pct, rv_delay, rv_pct;
  bit rv_data_fix, noise, rand_init;
  logic [15:0] rv_data;

  function automatic logic ack_of(int n);
    case (n) 0: return c0_ack; 1: return c1_ack; default: return c2_ack; endcase
  endfunction
  function automatic logic rv_of(int n);
    case (n) 0: return c0_rvalid; 1: return c1_rvalid; default: return c2_rvalid; endcase
  endfunction
  function automatic logic [15:0] rd_of(int n);
    case (n) 0: return c0_rdata; 1: return c1_rdata; default: return c2_rdata; endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acked = 0; m_to = 0; m_cli = 0; m_wait = 0; iss_cnt = 0;
    m_starve = 0; m_pref = 1; m_rv = -1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    for (int n = 0; n < 3; n++) begin m_rdata[n] = '0; got_ack[n] = 0; end
  endtask

  task automatic model_step();
    int w;
    int rv_nx;
    bit others;
    rv_nx  = -1;
    others = c_req[1] || c_req[2];
    if (!m_busy) begin
      if (init_done && (c_req[0] || others)) begin
        if (c_req[0] && !(others && m_starve == SMAX)) w = 0;
        else if (c_req[1] && c_req[2])               w = m_pref;
        else                                          w = c_req[1] ? 1 : 2;
        if (w == 0) m_starve = others ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        else begin m_starve = 0; m_pref = 3 - w; end
        m_cli = w; m_we = c_we[w]; m_addr = c_addr[w]; m_wdata = c_wdata[w]; m_be = c_be[w];
        gq.push_back(w);
        m_busy = 1; m_acked = 0; iss_cnt = 0;
      end
    end else if (!m_acked) begin
      if (ctrl_ack) begin
        if (m_we) m_busy = 0;
        else begin m_acked = 1; m_wait = 0; end
      end else iss_cnt++;
    end else begin
      if (ctrl_rvalid) begin
        m_rdata[m_cli] = ctrl_rdata; rv_nx = m_cli; m_busy = 0;
      end else begin
        m_wait++;
        if (m_wait == RTO) begin
          m_rdata[m_cli] = 16'hFFFF; rv_nx = m_cli; m_to = 1; m_busy = 0;
        end
      end
    end
    m_rv = rv_nx;
  endtask

  task automatic compare();
    logic e_req;
    e_req = m_busy && !m_acked;
    chk("ctrl_req", ctrl_req, e_req);
    chk("ctrl_we", ctrl_we, m_we);
    chk("ctrl_addr", ctrl_addr, m_addr);
    chk("ctrl_wdata", ctrl_wdata, m_wdata);
    chk("ctrl_be", ctrl_be, m_be);
    chk("rd_timeout", rd_timeout, m_to);
    for (int n = 0; n < 3; n++) begin
      got_ack[n] = e_req && ctrl_ack && (m_cli == n);
      chk($sformatf("c%0d_ack", n), ack_of(n), got_ack[n]);
      chk($sformatf("c%0d_rvalid", n), rv_of(n), m_rv == n);
      chk($sformatf("c%0d_rdata", n), rd_of(n), m_rdata[n]);
    end
  endtask

  task automatic new_req(int n);
    c_req[n]   = 1'b1;
    c_we[n]    = (wmode[n] == 2) ? 1'($urandom) : 1'(wmode[n]);
    c_addr[n]  = AW'($urandom);
    c_wdata[n] = 16'($urandom);
    c_be[n]    = 2'($urandom);
  endtask

  // The model advances for the coming edge with the inputs as they stand, so
  // inputs changed between calls are seen by both model and DUT.
  task automatic cycle();
    if (rst_n) model_step();
    @(posedge clk_sys);
    #1;
    if (!rst_n) model_reset();
    for (int n = 0; n < 3; n++) begin
      if (got_ack[n]) begin
        if (keep[n] != 0) new_req(n);
        else c_req[n] = 1'b0;
      end else if (!c_req[n] && int'($urandom_range(0, 99)) < want[n]) new_req(n);
    end
    ctrl_ack    = 1'b0;
    ctrl_rvalid = 1'b0;
    ctrl_rdata  = 16'($urandom);
    if (m_busy && !m_acked)
      ctrl_ack = (ack_delay >= 0) ? (iss_cnt == ack_delay) : (int'($urandom_range(0, 99)) < ack_pct);
    else if (noise) ctrl_ack = ($urandom_range(0, 3) == 0);
    if (m_busy && m_acked) begin
      if (rv_delay >= 0)       ctrl_rvalid = (m_wait == rv_delay);
      else if (rv_delay == -1) ctrl_rvalid = (int'($urandom_range(0, 99)) < rv_pct);
      if (rv_data_fix) ctrl_rdata = rv_data;
    end else if (noise) ctrl_rvalid = ($urandom_range(0, 3) == 0);
    if (rand_init && $urandom_range(0, 99) < 3) init_done = ~init_done;
    #4;
    compare();
  endtask

  task automatic drain();
    int k;
    k = 0;
    for (int n = 0; n < 3; n++) begin keep[n] = 0; want[n] = 0; end
    noise = 0; rand_init = 0; init_done = 1'b1; rv_data_fix = 0;
    ack_delay = 0; rv_delay = 0;
    while ((m_busy || c_req[0] || c_req[1] || c_req[2] || m_rv >= 0) && k < 300) begin
      cycle();
      k++;
    end
    chk("drain_bound", k < 300, 1'b1);
  endtask

  initial begin
    int t_req, t_ack, t_rv, cnt, n_other;
    logic [31:0] cap_we, cap_addr, cap_wd, cap_be, cap_rd, cap_to;
    int aq[$];
    int exp4[4];
    int exp5[10];
    exp4 = '{1, 2, 1, 2};
    exp5 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int n = 0; n < 3; n++) begin
      c_req[n] = 1'b0; c_we[n] = 1'b0; c_addr[n] = '0; c_wdata[n] = '0; c_be[n] = '0;
      want[n] = 0; keep[n] = 0; wmode[n] = 1;
    end
    model_reset();
    ack_delay = 0; ack_pct = 50; rv_delay = -1; rv_pct = 20;
    rv_data_fix = 0; rv_data = '0; noise = 0; rand_init = 0;

    // reset values, then no grants while init_done is low
    repeat (3) cycle();
    chk("rst_ctrl_req", ctrl_req, 1'b0);
    chk("rst_ctrl_we", ctrl_we, 1'b0);
    chk("rst_ctrl_addr", ctrl_addr, 0);
    chk("rst_c0_rdata", c0_rdata, 0);
    chk("rst_rd_timeout", rd_timeout, 1'b0);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) new_req(n);
    cnt = 0;
    repeat (20) begin cycle(); if (ctrl_req) cnt++; end
    chk("no_grant_before_init", cnt, 0);
    init_done = 1'b1;
    gq.delete();
    cycle();
    chk("init_req_next_cycle", ctrl_req, 1'b1);
    chk("init_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("init_addr", ctrl_addr, c_addr[0]);
    drain();

    // client 1 write acked on the fourth request cycle
    ack_delay = 3;
    c_we[1] = 1'b1; c_addr[1] = 22'h000123; c_wdata[1] = 16'hBEEF; c_be[1] = 2'b11; c_req[1] = 1'b1;
    t_req = -1; t_ack = -100; cnt = 0;
    cap_we = '0; cap_addr = '0; cap_wd = '0; cap_be = '0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (ctrl_req && t_req < 0) t_req = i;
      if (c1_ack) begin
        t_ack = i; cap_we = ctrl_we; cap_addr = ctrl_addr; cap_wd = ctrl_wdata; cap_be = ctrl_be;
      end
      if (c1_rvalid) cnt++;
    end
    chk("wr_ack_latency", t_ack - t_req, 3);
    chk("wr_we", cap_we, 1);
    chk("wr_addr", cap_addr, 32'h123);
    chk("wr_wdata", cap_wd, 32'hBEEF);
    chk("wr_be", cap_be, 3);
    chk("wr_no_rvalid", cnt, 0);
    drain();

    // client 2 read answered 6 cycles after ack
    ack_delay = 0; rv_delay = 5; rv_data_fix = 1; rv_data = 16'h1234;
    wmode[2] = 0; new_req(2);
    t_ack = -100; t_rv = -1; cap_rd = '0; n_other = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (c2_ack) t_ack = i;
      if (c2_rvalid) begin t_rv = i; cap_rd = c2_rdata; end
      if (c0_rvalid || c1_rvalid) n_other++;
    end
    chk("rd_rvalid_latency", t_rv - t_ack, 7);
    chk("rd_data", cap_rd, 32'h1234);
    chk("rd_other_rvalid", n_other, 0);
    drain();

    // clients 1 and 2 competing alternate
    wmode[1] = 1; wmode[2] = 1; keep[1] = 1; keep[2] = 1;
    new_req(1); new_req(2);
    gq.delete(); aq.delete();
    repeat (12) begin
      cycle();
      if (c0_ack) aq.push_back(0);
      if (c1_ack) aq.push_back(1);
      if (c2_ack) aq.push_back(2);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_model_%0d", i), (i < gq.size()) ? gq[i] : -1, exp4[i]);
      chk($sformatf("rr_dut_%0d", i), (i < aq.size()) ? aq[i] : -1, exp4[i]);
    end
    drain();

    // client 0 against client 1 with the starvation limit
    wmode[0] = 1; wmode[1] = 1; keep[0] = 1; keep[1] = 1;
    new_req(0); new_req(1);
    gq.delete(); aq.delete();
    repeat (24) begin
      cycle();
      if (c0_ack) aq.push_back(0);
      if (c1_ack) aq.push_back(1);
      if (c2_ack) aq.push_back(2);
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("starve_model_%0d", i), (i < gq.size()) ? gq[i] : -1, exp5[i]);
      chk($sformatf("starve_dut_%0d", i), (i < aq.size()) ? aq[i] : -1, exp5[i]);
    end
    drain();

    // unanswered read times out, flag sticks until reset
    rv_delay = -2;
    wmode[0] = 0; new_req(0);
    t_ack = -100; t_rv = -1; cap_rd = '0; cap_to = '0;
    for (int i = 0; i < 90; i++) begin
      cycle();
      if (c0_ack) t_ack = i;
      if (c0_rvalid) begin t_rv = i; cap_rd = c0_rdata; cap_to = rd_timeout; end
    end
    chk("to_latency", t_rv - t_ack, RTO + 1);
    chk("to_rdata", cap_rd, 32'hFFFF);
    chk("to_flag", cap_to, 1);
    wmode[1] = 1; new_req(1);
    cnt = 0;
    repeat (10) begin cycle(); if (c1_ack) cnt++; end
    chk("after_to_ack", cnt, 1);
    chk("to_flag_sticky", rd_timeout, 1'b1);
    rst_n = 1'b0;
    cycle();
    chk("to_flag_reset", rd_timeout, 1'b0);
    chk("reset_c0_rdata", c0_rdata, 0);
    rst_n = 1'b1;
    drain();

    // random traffic with noise, init_done toggling and a mid-run reset
    for (int n = 0; n < 3; n++) begin want[n] = 25; keep[n] = int'($urandom_range(0, 1)); wmode[n] = 2; end
    ack_delay = -1; ack_pct = 40; rv_delay = -1; rv_pct = 15; noise = 1; rand_init = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) rst_n = 1'b0;
      if (i == 1002) rst_n = 1'b1;
      cycle();
    end
    rv_pct = 2;
    for (int n = 0; n < 3; n++) keep[n] = int'($urandom_range(0, 1));
    repeat (1500) cycle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
